// File: rtl/dpi_stream_sequencer.sv
// Flow-keyed byte-stream sequencer driving the DPI regex-bank control bus.
// Maps flow keys to stream ids through a direct-mapped table and paces load/stream/eop.
module dpi_stream_sequencer #(
    parameter int NUM_REGEX = 16,
    parameter int LOAD_GAP  = 3,
    parameter int DRAIN_GAP = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [7:0]           in_data,
    input  logic                 in_sop,
    input  logic                 in_eop,
    input  logic [31:0]          in_key,
    input  logic                 cfg_we,
    input  logic [5:0]           cfg_addr,
    input  logic [NUM_REGEX-1:0] cfg_data,
    output logic                 load_state,
    output logic [5:0]           stream_id,
    output logic                 new_stream_id,
    output logic [7:0]           char_in,
    output logic                 char_in_vld,
    output logic                 eop,
    output logic [NUM_REGEX-1:0] enable,
    output logic [15:0]          pkt_count,
    output logic                 proto_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_LOAD,
        S_GAP,
        S_STREAM,
        S_DRAIN,
        S_EOP
    } state_t;

    // The LOAD cycle counts toward the load gap, so GAP itself lasts LOAD_GAP-1.
    localparam logic [7:0] GAP_LAST   = 8'(LOAD_GAP - 2);
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_GAP);

    state_t state, state_nx;

    logic [31:0]          key_q;
    logic                 hit_q;
    logic                 first_q;
    logic [7:0]           cnt_q;
    logic [63:0]          flow_valid;
    logic [25:0]          flow_tag [64];
    logic [NUM_REGEX-1:0] mask_tbl [64];

    logic [5:0]  idx;
    logic [25:0] key_tag;
    logic        beat_acc;

    assign idx      = key_q[5:0];
    assign key_tag  = key_q[31:6];
    assign beat_acc = (state == S_STREAM) && in_valid;

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        proto_err = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (in_valid) begin
                    if (in_sop) begin
                        state_nx = S_LOOKUP;
                    end else begin
                        in_ready  = 1'b1;
                        proto_err = 1'b1;
                    end
                end
            end
            S_LOOKUP: state_nx = S_LOAD;
            S_LOAD:   state_nx = S_GAP;
            S_GAP: begin
                if (cnt_q == GAP_LAST)
                    state_nx = S_STREAM;
            end
            S_STREAM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_sop && !first_q)
                        proto_err = 1'b1;
                    if (in_eop)
                        state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST)
                    state_nx = S_EOP;
            end
            S_EOP:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            key_q       <= '0;
            hit_q       <= 1'b0;
            first_q     <= 1'b0;
            cnt_q       <= '0;
            char_in     <= '0;
            char_in_vld <= 1'b0;
            pkt_count   <= '0;
            flow_valid  <= '0;
        end else begin
            state <= state_nx;
            cnt_q <= (state_nx != state) ? 8'd0 : cnt_q + 8'd1;
            if (state == S_IDLE && in_valid && in_sop)
                key_q <= in_key;
            if (state == S_LOOKUP)
                hit_q <= flow_valid[idx] && (flow_tag[idx] == key_tag);
            if (state == S_LOAD)
                first_q <= 1'b1;
            else if (beat_acc)
                first_q <= 1'b0;
            if (state == S_LOAD && !hit_q)
                flow_valid[idx] <= 1'b1;
            char_in_vld <= beat_acc;
            if (beat_acc)
                char_in <= in_data;
            if (state == S_EOP)
                pkt_count <= pkt_count + 16'd1;
        end
    end

    // Tags are qualified by flow_valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && !hit_q)
            flow_tag[idx] <= key_tag;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 64; i++)
                mask_tbl[i] <= '0;
        end else if (cfg_we) begin
            mask_tbl[cfg_addr] <= cfg_data;
        end
    end

    assign load_state    = (state == S_LOAD);
    assign new_stream_id = load_state && !hit_q;
    assign stream_id     = idx;
    assign eop           = (state == S_EOP);
    assign enable        = eop ? mask_tbl[idx] : '0;

endmodule
